// File: rtl/tone_direction_decoder_pkg.sv
// Shared direction codes, decoder state encoding and edge-count helpers for the
// tone direction decoder.
package tone_direction_decoder_pkg;

  typedef enum logic [2:0] {
    TD_HOLD    = 3'd0,
    TD_FORWARD = 3'd1,
    TD_LEFT    = 3'd2,
    TD_RIGHT   = 3'd3,
    TD_REVERSE = 3'd4,
    TD_STOP    = 3'd5
  } toneDir_e;

  typedef enum logic [1:0] {
    TDD_IDLE    = 2'd0,
    TDD_MEASURE = 2'd1,
    TDD_DECIDED = 2'd2
  } tddState_e;

  localparam int EDGE_COUNT_W = 8;
  localparam logic [EDGE_COUNT_W-1:0] EDGE_COUNT_MAX = 8'd255;

  // Edge counter increment that sticks at full scale instead of wrapping.
  function automatic logic [EDGE_COUNT_W-1:0] satAdd(input logic [EDGE_COUNT_W-1:0] count,
                                                     input logic inc);
    if (count == EDGE_COUNT_MAX) return EDGE_COUNT_MAX;
    return count + {{(EDGE_COUNT_W-1){1'b0}}, inc};
  endfunction

endpackage

// File: rtl/tone_direction_decoder_sync.sv
// Two-flop synchronizer for the asynchronous comparator tone, followed by a
// single-cycle rising-edge pulse.
module tone_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic toneIn,
  output logic risingEdge
);

  logic syncMeta;
  logic syncOut;
  logic syncPrev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      syncMeta <= 1'b0;
      syncOut  <= 1'b0;
      syncPrev <= 1'b0;
    end else begin
      syncMeta <= toneIn;
      syncOut  <= syncMeta;
      syncPrev <= syncOut;
    end
  end

  assign risingEdge = syncOut & ~syncPrev;

endmodule

// File: rtl/tone_direction_decoder.sv
// Measures beacon tone frequency over fixed gate windows, classifies it into a
// direction code and publishes it after enough consecutive agreeing windows.
module tone_direction_decoder
  import tone_direction_decoder_pkg::*;
#(
  parameter int GATE_CYCLES     = 2_500_000,
  parameter int EDGES_FORWARD   = 50,
  parameter int EDGES_LEFT      = 75,
  parameter int EDGES_RIGHT     = 100,
  parameter int EDGES_REVERSE   = 125,
  parameter int EDGES_STOP      = 150,
  parameter int TOL_EDGES       = 5,
  parameter int CONFIRM_WINDOWS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       toneIn,
  input  logic       enableToneDetection,
  output logic [2:0] toneDir,
  output logic       toneValid,
  output logic [7:0] lastEdgeCount,
  output logic       windowDone
);

  localparam int WIN_W = $clog2(GATE_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);
  localparam logic [2:0] CONFIRM_COUNT = 3'(CONFIRM_WINDOWS);

  tddState_e                 state;
  toneDir_e                  toneDirReg;
  toneDir_e                  candidate;
  logic [2:0]                matchCount;
  logic [WIN_W-1:0]          windowCnt;
  logic [EDGE_COUNT_W-1:0]   edgeCnt;
  logic                      risingEdge;
  logic [EDGE_COUNT_W-1:0]   windowTotal;
  toneDir_e                  windowClass;
  logic [2:0]                nextMatch;

  tone_sync_edge uSyncEdge (
    .clk        (clk),
    .rst        (rst),
    .toneIn     (toneIn),
    .risingEdge (risingEdge)
  );

  // Distance is taken in 9-bit signed so a count below nominal cannot wrap.
  function automatic logic inBand(input logic [EDGE_COUNT_W-1:0] count, input int nominal);
    logic signed [8:0] diff;
    diff = $signed({1'b0, count}) - $signed(9'(nominal));
    if (diff < 0) diff = -diff;
    return diff <= $signed(9'(TOL_EDGES));
  endfunction

  function automatic toneDir_e classifyCount(input logic [EDGE_COUNT_W-1:0] count);
    if (inBand(count, EDGES_FORWARD)) return TD_FORWARD;
    if (inBand(count, EDGES_LEFT))    return TD_LEFT;
    if (inBand(count, EDGES_RIGHT))   return TD_RIGHT;
    if (inBand(count, EDGES_REVERSE)) return TD_REVERSE;
    if (inBand(count, EDGES_STOP))    return TD_STOP;
    return TD_HOLD;
  endfunction

  assign windowTotal = satAdd(edgeCnt, risingEdge);
  assign windowClass = classifyCount(windowTotal);
  assign nextMatch   = (windowClass == candidate) ? matchCount + 3'd1 : 3'd1;

  // Enable low aborts from any state, taking priority over a window ending.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= TDD_IDLE;
      toneDirReg    <= TD_HOLD;
      toneValid     <= 1'b0;
      lastEdgeCount <= '0;
      windowDone    <= 1'b0;
      windowCnt     <= '0;
      edgeCnt       <= '0;
      candidate     <= TD_HOLD;
      matchCount    <= '0;
    end else if (!enableToneDetection) begin
      state      <= TDD_IDLE;
      toneDirReg <= TD_HOLD;
      toneValid  <= 1'b0;
      windowDone <= 1'b0;
      windowCnt  <= '0;
      edgeCnt    <= '0;
      candidate  <= TD_HOLD;
      matchCount <= '0;
    end else begin
      case (state)
        TDD_IDLE: begin
          windowDone <= 1'b0;
          windowCnt  <= '0;
          edgeCnt    <= '0;
          state      <= TDD_MEASURE;
        end
        TDD_MEASURE: begin
          if (windowCnt == WIN_LAST) begin
            windowDone    <= 1'b1;
            lastEdgeCount <= windowTotal;
            windowCnt     <= '0;
            edgeCnt       <= '0;
            if (windowClass == TD_HOLD) begin
              candidate  <= TD_HOLD;
              matchCount <= '0;
            end else begin
              candidate  <= windowClass;
              matchCount <= nextMatch;
              if (nextMatch == CONFIRM_COUNT) begin
                toneDirReg <= windowClass;
                toneValid  <= 1'b1;
                state      <= TDD_DECIDED;
              end
            end
          end else begin
            windowDone <= 1'b0;
            windowCnt  <= windowCnt + WIN_W'(1);
            edgeCnt    <= windowTotal;
          end
        end
        TDD_DECIDED: begin
          windowDone <= 1'b0;
        end
        default: begin
          state <= TDD_IDLE;
        end
      endcase
    end
  end

  assign toneDir = toneDirReg;

endmodule

// File: tb/tb_tone_direction_decoder.sv
// Directed-vector bench for tone_direction_decoder with a window-level reference
// model checked every cycle, plus literal spot checks of key scenarios.
module tb_tone_direction_decoder;

  localparam int GATE    = 1000;
  localparam int TOL     = 1;
  localparam int CONFIRM = 3;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic       toneIn = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] toneDir;
  logic       toneValid;
  logic [7:0] lastEdgeCount;
  logic       windowDone;

  int vectors     = 0;
  int miscompares = 0;
  int wdPulses    = 0;

  always #5 clk = ~clk;

  tone_direction_decoder #(
    .GATE_CYCLES     (GATE),
    .EDGES_FORWARD   (10),
    .EDGES_LEFT      (15),
    .EDGES_RIGHT     (20),
    .EDGES_REVERSE   (25),
    .EDGES_STOP      (30),
    .TOL_EDGES       (TOL),
    .CONFIRM_WINDOWS (CONFIRM)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .toneIn              (toneIn),
    .enableToneDetection (enable),
    .toneDir             (toneDir),
    .toneValid           (toneValid),
    .lastEdgeCount       (lastEdgeCount),
    .windowDone          (windowDone)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Window-level reference: count rising edges per window, classify by band, and
  // decide once the last CONFIRM classifications are the same valid code.
  int  nominal [5] = '{10, 15, 20, 25, 30};
  int  hist [$];
  int  mDir = 0, mValid = 0, mLast = 0, mWd = 0;
  int  mPos = 0, mEdges = 0;
  bit  mMeasuring = 0, mDecided = 0, armed = 0;
  logic prevTone = 1'b0;

  function automatic int classify(input int count);
    for (int i = 0; i < 5; i++) begin
      int d;
      d = count - nominal[i];
      if (d < 0) d = -d;
      if (d <= TOL) return i + 1;
    end
    return 0;
  endfunction

  function automatic bit confirmed(input int code);
    if (code == 0 || hist.size() < CONFIRM) return 0;
    for (int i = hist.size() - CONFIRM; i < hist.size(); i++)
      if (hist[i] != code) return 0;
    return 1;
  endfunction

  always @(posedge clk) begin : model
    int total;
    int code;
    bit rose;
    rose = toneIn && !prevTone;
    prevTone = toneIn;
    mWd = 0;
    if (!rst) begin
      armed = 1; mDir = 0; mValid = 0; mLast = 0;
      mMeasuring = 0; mDecided = 0; mPos = 0; mEdges = 0;
      hist.delete();
    end else if (!enable) begin
      mDir = 0; mValid = 0; mMeasuring = 0; mDecided = 0;
      mPos = 0; mEdges = 0;
      hist.delete();
    end else if (mDecided) begin
      mWd = 0;
    end else if (!mMeasuring) begin
      mMeasuring = 1; mPos = 0; mEdges = 0;
    end else begin
      if (rose) mEdges++;
      if (mPos == GATE - 1) begin
        total = (mEdges > 255) ? 255 : mEdges;
        code  = classify(total);
        mLast = total;
        mWd   = 1;
        mPos  = 0;
        mEdges = 0;
        hist.push_back(code);
        if (confirmed(code)) begin
          mDir = code; mValid = 1; mDecided = 1;
        end
      end else begin
        mPos++;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      checkOutput("model toneDir", toneDir, mDir);
      checkOutput("model toneValid", toneValid, mValid);
      checkOutput("model lastEdgeCount", lastEdgeCount, mLast);
      checkOutput("model windowDone", windowDone, mWd);
    end
    if (windowDone === 1'b1) wdPulses++;
  end

  // Drives numEdges rising edges mid-window, spread across numCycles clocks.
  task automatic applyStimulus(input int numEdges, input int numCycles);
    int period;
    period = (numEdges > 40) ? 2 : 20;
    for (int t = 0; t < numCycles; t++) begin
      @(negedge clk);
      if (t >= 50 && t < 50 + numEdges * period)
        toneIn = ((t - 50) % period) < (period / 2);
      else
        toneIn = 1'b0;
    end
  endtask

  task automatic setEnable(input logic value);
    @(negedge clk);
    enable = value;
    toneIn = 1'b0;
  endtask

  initial begin
    // Test 1: reset with the tone toggling.
    repeat (5) begin
      @(negedge clk);
      toneIn = ~toneIn;
    end
    checkOutput("t1 toneDir", toneDir, 0);
    checkOutput("t1 toneValid", toneValid, 0);
    checkOutput("t1 lastEdgeCount", lastEdgeCount, 0);
    checkOutput("t1 windowDone", windowDone, 0);
    @(negedge clk);
    rst = 1'b1;
    toneIn = 1'b0;
    repeat (3) @(negedge clk);

    // Test 2: three windows of 20 edges decide RIGHT one clock after the third.
    setEnable(1'b1);
    repeat (3) applyStimulus(20, GATE);
    checkOutput("t2 pre toneValid", toneValid, 0);
    checkOutput("t2 pre toneDir", toneDir, 0);
    @(negedge clk);
    checkOutput("t2 toneDir", toneDir, 3);
    checkOutput("t2 toneValid", toneValid, 1);
    checkOutput("t2 lastEdgeCount", lastEdgeCount, 20);
    checkOutput("t2 windowDone", windowDone, 1);
    repeat (5) @(negedge clk);
    checkOutput("t2 hold toneDir", toneDir, 3);
    setEnable(1'b0);
    @(negedge clk);
    checkOutput("t2 drop toneDir", toneDir, 0);
    checkOutput("t2 drop toneValid", toneValid, 0);
    checkOutput("t2 drop lastEdgeCount", lastEdgeCount, 20);

    // Test 3: 15,15,21,21,21 -> candidate switches, RIGHT after window 5.
    setEnable(1'b1);
    applyStimulus(15, GATE);
    applyStimulus(15, GATE);
    applyStimulus(21, GATE);
    checkOutput("t3 w2 toneDir", toneDir, 0);
    checkOutput("t3 w2 lastEdgeCount", lastEdgeCount, 15);
    applyStimulus(21, GATE);
    applyStimulus(21, GATE);
    checkOutput("t3 w4 toneValid", toneValid, 0);
    @(negedge clk);
    checkOutput("t3 toneDir", toneDir, 3);
    checkOutput("t3 lastEdgeCount", lastEdgeCount, 21);
    setEnable(1'b0);

    // Test 4: an invalid 13 breaks the run; FORWARD only after window 6.
    setEnable(1'b1);
    wdPulses = 0;
    applyStimulus(10, GATE);
    applyStimulus(10, GATE);
    applyStimulus(13, GATE);
    applyStimulus(10, GATE);
    applyStimulus(10, GATE);
    checkOutput("t4 w4 toneDir", toneDir, 0);
    applyStimulus(10, GATE);
    checkOutput("t4 w5 toneDir", toneDir, 0);
    @(negedge clk);
    checkOutput("t4 toneDir", toneDir, 1);
    checkOutput("t4 toneValid", toneValid, 1);
    checkOutput("t4 lastEdgeCount", lastEdgeCount, 10);
    @(negedge clk);
    checkOutput("t4 windowDone pulses", wdPulses, 6);

    // Test 5: decided LEFT, abort, then STOP after exactly three fresh windows.
    setEnable(1'b0);
    setEnable(1'b1);
    repeat (3) applyStimulus(15, GATE);
    @(negedge clk);
    checkOutput("t5 left toneDir", toneDir, 2);
    repeat (3) @(negedge clk);
    setEnable(1'b0);
    @(negedge clk);
    checkOutput("t5 abort toneDir", toneDir, 0);
    checkOutput("t5 abort toneValid", toneValid, 0);
    setEnable(1'b1);
    repeat (3) applyStimulus(30, GATE);
    checkOutput("t5 pre toneDir", toneDir, 0);
    @(negedge clk);
    checkOutput("t5 stop toneDir", toneDir, 5);
    checkOutput("t5 stop toneValid", toneValid, 1);
    checkOutput("t5 stop lastEdgeCount", lastEdgeCount, 30);

    // Test 6: mid-window abort, mid-window reset, then saturating windows.
    setEnable(1'b0);
    setEnable(1'b1);
    applyStimulus(10, 400);
    applyStimulus(0, 5);
    setEnable(1'b0);
    @(negedge clk);
    checkOutput("t6 abort toneValid", toneValid, 0);
    checkOutput("t6 abort lastEdgeCount", lastEdgeCount, 30);
    checkOutput("t6 abort windowDone", windowDone, 0);
    setEnable(1'b1);
    repeat (2) applyStimulus(20, GATE);
    applyStimulus(8, 300);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t6 rst toneDir", toneDir, 0);
    checkOutput("t6 rst toneValid", toneValid, 0);
    checkOutput("t6 rst lastEdgeCount", lastEdgeCount, 0);
    checkOutput("t6 rst windowDone", windowDone, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) applyStimulus(400, GATE);
    checkOutput("t6 sat w2 lastEdgeCount", lastEdgeCount, 255);
    checkOutput("t6 sat w2 toneDir", toneDir, 0);
    @(negedge clk);
    checkOutput("t6 sat lastEdgeCount", lastEdgeCount, 255);
    checkOutput("t6 sat windowDone", windowDone, 1);
    checkOutput("t6 sat toneDir", toneDir, 0);
    checkOutput("t6 sat toneValid", toneValid, 0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
